// File: rtl/opll_slot_scheduler.sv
// Slot/stage timebase for the FM operator pipeline, plus the arbiter for the
// second read port of the output memory (mixer has fixed priority over host).
module opll_slot_scheduler #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned NUM_SLOTS  = 18,
    parameter int unsigned NUM_STAGES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    output logic        clkena,
    output logic [4:0]  slot,
    output logic [1:0]  stage,
    output logic        frame_start,
    input  logic        mix_req,
    input  logic [4:0]  mix_slot,
    output logic        mix_valid,
    output logic [9:0]  mix_data,
    input  logic        host_req,
    input  logic [4:0]  host_slot,
    output logic        host_ack,
    output logic [9:0]  host_data,
    output logic [4:0]  maddr,
    input  logic [9:0]  mdata
);

    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SLOT_W  = 5;
    localparam int unsigned STAGE_W = 2;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_MIX  = 2'd1,
        TAG_HOST = 2'd2
    } tag_t;

    logic [DIV_W-1:0]   div_q;
    logic               div_wrap_c;
    logic [SLOT_W-1:0]  slot_nxt_c;
    logic [STAGE_W-1:0] stage_nxt_c;

    tag_t              tag1_q;
    tag_t              tag2_q;
    tag_t              grant_tag_c;
    logic [SLOT_W-1:0] grant_addr_c;
    logic              busy_q;

    assign div_wrap_c = (div_q == DIV_W'(CLK_DIV - 1));

    // Position the pipeline moves to when the current strobe is consumed.
    always_comb begin
        slot_nxt_c  = slot;
        stage_nxt_c = stage;
        if (clkena) begin
            if (stage == STAGE_W'(NUM_STAGES - 1)) begin
                stage_nxt_c = '0;
                slot_nxt_c  = (slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : slot + SLOT_W'(1);
            end else begin
                stage_nxt_c = stage + STAGE_W'(1);
            end
        end
    end

    // Divider, strobe and slot/stage registers; run=0 freezes the divider only,
    // so a strobe already issued is still consumed and nothing is skipped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q       <= '0;
            clkena      <= 1'b0;
            frame_start <= 1'b0;
            slot        <= '0;
            stage       <= '0;
        end else begin
            slot  <= slot_nxt_c;
            stage <= stage_nxt_c;
            if (run) begin
                div_q       <= div_wrap_c ? '0 : div_q + DIV_W'(1);
                clkena      <= div_wrap_c;
                frame_start <= div_wrap_c && (slot_nxt_c == '0) && (stage_nxt_c == '0);
            end else begin
                clkena      <= 1'b0;
                frame_start <= 1'b0;
            end
        end
    end

    // Grant decision: mixer always wins, host only when no host read is in flight.
    always_comb begin
        grant_tag_c  = TAG_NONE;
        grant_addr_c = maddr;
        if (mix_req) begin
            grant_tag_c  = TAG_MIX;
            grant_addr_c = mix_slot;
        end else if (host_req && !busy_q) begin
            grant_tag_c  = TAG_HOST;
            grant_addr_c = host_slot;
        end
    end

    // Two-stage tag pipeline matching the memory's one-cycle read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            maddr     <= '0;
            tag1_q    <= TAG_NONE;
            tag2_q    <= TAG_NONE;
            busy_q    <= 1'b0;
            mix_valid <= 1'b0;
            mix_data  <= '0;
            host_ack  <= 1'b0;
            host_data <= '0;
        end else begin
            maddr     <= grant_addr_c;
            tag1_q    <= grant_tag_c;
            tag2_q    <= tag1_q;
            mix_valid <= (tag2_q == TAG_MIX);
            host_ack  <= (tag2_q == TAG_HOST);
            if (grant_tag_c == TAG_HOST) begin
                busy_q <= 1'b1;
            end
            if (tag2_q == TAG_MIX) begin
                mix_data <= mdata;
            end
            if (tag2_q == TAG_HOST) begin
                host_data <= mdata;
                busy_q    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_opll_slot_scheduler.sv
// Bench for opll_slot_scheduler: arithmetic timebase model plus a response
// scoreboard for the memory read-port arbiter, directed cases then random traffic.
module tb_opll_slot_scheduler;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned NUM_SLOTS  = 18;
    localparam int unsigned NUM_STAGES = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       run = 1'b0;
    logic       clkena;
    logic [4:0] slot;
    logic [1:0] stage;
    logic       frame_start;
    logic       mix_req = 1'b0;
    logic [4:0] mix_slot = '0;
    logic       mix_valid;
    logic [9:0] mix_data;
    logic       host_req = 1'b0;
    logic [4:0] host_slot = '0;
    logic       host_ack;
    logic [9:0] host_data;
    logic [4:0] maddr;
    logic [9:0] mdata;

    logic [9:0] mem [32];

    typedef struct {
        logic       is_host;
        logic [9:0] data;
        int         due;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         cyc = 0;
    int         steps = 0;
    int         run_edges = 0;
    logic       e_clkena = 1'b0;
    logic       e_fs = 1'b0;
    int         e_slot = 0;
    int         e_stage = 0;
    logic [4:0] e_maddr = '0;
    logic       busy = 1'b0;
    int         busy_until = 0;

    opll_slot_scheduler #(
        .CLK_DIV   (CLK_DIV),
        .NUM_SLOTS (NUM_SLOTS),
        .NUM_STAGES(NUM_STAGES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .clkena     (clkena),
        .slot       (slot),
        .stage      (stage),
        .frame_start(frame_start),
        .mix_req    (mix_req),
        .mix_slot   (mix_slot),
        .mix_valid  (mix_valid),
        .mix_data   (mix_data),
        .host_req   (host_req),
        .host_slot  (host_slot),
        .host_ack   (host_ack),
        .host_data  (host_data),
        .maddr      (maddr),
        .mdata      (mdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read output memory seen by port 2.
    always_ff @(posedge clk) mdata <= mem[maddr];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    // Reference model: sequencer position from strobe count, arbiter as grant list.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                steps = 0; run_edges = 0; e_clkena = 1'b0; e_fs = 1'b0;
                e_slot = 0; e_stage = 0; e_maddr = '0; busy = 1'b0;
                q.delete();
            end else begin
                cyc++;
                if (e_clkena) steps++;
                if (run) begin
                    run_edges++;
                    e_clkena = ((run_edges % CLK_DIV) == 0);
                end else begin
                    e_clkena = 1'b0;
                end
                e_slot  = (steps / NUM_STAGES) % NUM_SLOTS;
                e_stage = steps % NUM_STAGES;
                e_fs    = e_clkena && ((steps % (NUM_SLOTS * NUM_STAGES)) == 0);
                if (mix_req) begin
                    e_maddr = mix_slot;
                    e.is_host = 1'b0; e.data = mem[mix_slot]; e.due = cyc + 2;
                    q.push_back(e);
                end else if (host_req && !busy) begin
                    e_maddr = host_slot;
                    e.is_host = 1'b1; e.data = mem[host_slot]; e.due = cyc + 2;
                    q.push_back(e);
                    busy = 1'b1;
                    busy_until = cyc + 2;
                end
                if (busy && cyc == busy_until) busy = 1'b0;
            end
        end
    end

    // Monitor: compare every cycle on the falling edge.
    initial begin
        exp_t       e;
        logic       got;
        logic [9:0] last_mix;
        logic [9:0] last_host;
        last_mix = '0;
        last_host = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                last_mix = '0;
                last_host = '0;
                check("reset_outputs",
                      64'({clkena, frame_start, slot, stage, maddr, mix_valid, mix_data, host_ack, host_data}),
                      64'd0);
            end else begin
                check("seq {clkena,fs,slot,stage}",
                      64'({clkena, frame_start, slot, stage}),
                      64'({e_clkena, e_fs, 5'(e_slot), 2'(e_stage)}));
                check("maddr", 64'(maddr), 64'(e_maddr));
                got = 1'b0;
                e.is_host = 1'b0;
                if (q.size() > 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    got = 1'b1;
                    if (e.is_host) last_host = e.data;
                    else           last_mix  = e.data;
                end
                check("mix_valid", 64'(mix_valid), 64'(got && !e.is_host));
                check("host_ack",  64'(host_ack),  64'(got && e.is_host));
                check("mix_data",  64'(mix_data),  64'(last_mix));
                check("host_data", 64'(host_data), 64'(last_host));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_host_ack(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (host_ack) begin
                host_req = 1'b0;
                seen = 1'b1;
            end
        end
        check(name, 64'(seen), 64'd1);
        host_req = 1'b0;
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 32; i++) begin
            mem[i] = (i < int'(NUM_SLOTS)) ? 10'(i + 100) : 10'($urandom);
        end
        #1 reset_n = 1'b0;
        run = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;

        // Free-running timebase across more than one frame.
        repeat (320) tick();

        // Pause at slot 5 stage 2 for 37 clocks.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            if (e_slot == 5 && e_stage == 2) found = 1'b1;
        end
        check("reach_slot5_stage2", 64'(found), 64'd1);
        run = 1'b0;
        repeat (37) tick();
        run = 1'b1;
        repeat (300) tick();

        // Mixer burst of three reads.
        mix_req = 1'b1;
        for (int i = 3; i <= 5; i++) begin
            mix_slot = 5'(i);
            tick();
        end
        mix_req = 1'b0;
        repeat (4) tick();

        // Single host read, dropped on ack.
        host_req = 1'b1;
        host_slot = 5'd7;
        wait_host_ack("host_read_slot7");
        repeat (4) tick();

        // Host and mixer contend; mixer holds the port for five cycles.
        mix_req = 1'b1;
        host_req = 1'b1;
        host_slot = 5'd9;
        for (int i = 0; i < 5; i++) begin
            mix_slot = 5'(10 + i);
            tick();
        end
        mix_req = 1'b0;
        wait_host_ack("host_after_mix_burst");
        repeat (4) tick();

        // Reset one cycle after a host grant: the response must vanish.
        host_req = 1'b1;
        host_slot = 5'd2;
        tick();
        tick();
        reset_n = 1'b0;
        host_req = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (20) tick();

        // Random traffic with occasional run pauses.
        for (int i = 0; i < 2000; i++) begin
            run = ($urandom_range(0, 15) != 0);
            mix_req = ($urandom_range(0, 9) < 4);
            mix_slot = 5'($urandom_range(0, 31));
            if (host_req && host_ack) begin
                host_req = 1'b0;
            end else if (!host_req && $urandom_range(0, 3) == 0) begin
                host_req = 1'b1;
                host_slot = 5'($urandom_range(0, 31));
            end
            tick();
        end
        mix_req = 1'b0;
        for (int i = 0; i < 40 && host_req; i++) begin
            if (host_ack) host_req = 1'b0;
            tick();
        end
        host_req = 1'b0;
        repeat (6) tick();
        check("scoreboard_empty", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
